ysyx_220066_divider: RTL and testbench

Iterative integer divide/remainder unit for the ysyx_220066 RV64 core; it executes RV64M DIV/DIVU/REM/REMU and their W variants. It sits beside the EX stage: ID issues an op, the unit computes it over multiple cycles and hands a result to write-back. While the op is in flight it reports the pending destination register so the register file can hold dependent reads. One operation is in flight at a time.

---
 rtl/ysyx_220066_divider_pkg.sv | 33 +++
 rtl/ysyx_220066_divider_if.sv | 38 +++
 rtl/ysyx_220066_div_step.sv | 28 ++
 rtl/ysyx_220066_divider.sv | 157 +++++++++++++++
 tb/tb_ysyx_220066_divider.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/ysyx_220066_divider_pkg.sv
// Shared types and helpers for the ysyx_220066 iterative divider.
package ysyx_220066_divider_pkg;

  localparam int XLEN = 64;

  // ALUctr encodings: bit 1 selects remainder, bit 0 selects unsigned.
  typedef enum logic [1:0] {
    ALU_DIV  = 2'b00,
    ALU_DIVU = 2'b01,
    ALU_REM  = 2'b10,
    ALU_REMU = 2'b11
  } alu_ctr_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  function automatic logic is_signed_op(input logic [1:0] ctr);
    return (ctr == ALU_DIV) || (ctr == ALU_REM);
  endfunction

  function automatic logic is_rem_op(input logic [1:0] ctr);
    return (ctr == ALU_REM) || (ctr == ALU_REMU);
  endfunction

  // Widen a 32-bit value, sign- or zero-extending.
  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
    return {{32{sgn & v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_220066_divider_if.sv
// Issue/result bus between ID, the divider and write-back.
// Handshake: an op is taken on a rising edge where valid_in && ready; valid_in
// while ready=0 is ignored and upstream keeps the op. A result is offered while
// valid=1 and is consumed on the first edge with block=0; with block=1 every
// output holds.
interface ysyx_220066_divider_if;
  import ysyx_220066_divider_pkg::*;

  logic             block;
  logic             valid_in;
  logic             error_in;
  logic [XLEN-1:0]  nxtpc_in;
  logic [XLEN-1:0]  src1_in;
  logic [XLEN-1:0]  src2_in;
  logic [1:0]       ALUctr_in;
  logic             is_w_in;
  logic [4:0]       rd_in;

  logic             ready;
  logic             valid_part;
  logic [4:0]       rd_part;
  logic             valid;
  logic [4:0]       rd;
  logic [XLEN-1:0]  result;
  logic             error;
  logic [XLEN-1:0]  nxtpc;
  div_state_e       state_dbg;

  modport slave (
    input  block, valid_in, error_in, nxtpc_in, src1_in, src2_in, ALUctr_in, is_w_in, rd_in,
    output ready, valid_part, rd_part, valid, rd, result, error, nxtpc, state_dbg
  );

  modport master (
    output block, valid_in, error_in, nxtpc_in, src1_in, src2_in, ALUctr_in, is_w_in, rd_in,
    input  ready, valid_part, rd_part, valid, rd, result, error, nxtpc, state_dbg
  );
endinterface

// File: rtl/ysyx_220066_div_step.sv
// One restoring radix-2 step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module ysyx_220066_div_step
  import ysyx_220066_divider_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);
  // The shifted remainder can reach 2*divisor-1, so it needs one extra bit.
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  // Trial subtraction and restore.
  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted[XLEN-1:0] - dvs_i;
    if (shifted >= {1'b0, dvs_i}) begin
      rem_o = diff;
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = shifted[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/ysyx_220066_divider.sv
// Iterative RV64M divide/remainder unit: FSM, counter, operand latching,
// special-case shortcut and final sign/width fix-up.
module ysyx_220066_divider
  import ysyx_220066_divider_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  ysyx_220066_divider_if.slave  bus
);
  div_state_e      state_q, state_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic            negq_q, negq_d, negr_q, negr_d, is_rem_q, is_rem_d, is_w_q, is_w_d;
  logic [4:0]      rd_part_q, rd_part_d, rd_q, rd_d;
  logic [XLEN-1:0] result_q, result_d, nxtpc_q, nxtpc_d;
  logic            error_q, error_d;

  // Issue-side decode of the incoming op.
  logic            sgn_in, rem_in, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_w, mag_a, mag_b, quo_spec, rem_spec, spec_res;

  assign sgn_in = is_signed_op(bus.ALUctr_in);
  assign rem_in = is_rem_op(bus.ALUctr_in);
  assign a_ext  = bus.is_w_in ? ext32(bus.src1_in[31:0], sgn_in) : bus.src1_in;
  assign b_ext  = bus.is_w_in ? ext32(bus.src2_in[31:0], sgn_in) : bus.src2_in;
  assign a_w    = ext32(bus.src1_in[31:0], 1'b1);
  assign a_neg  = sgn_in & a_ext[XLEN-1];
  assign b_neg  = sgn_in & b_ext[XLEN-1];
  assign mag_a  = a_neg ? -a_ext : a_ext;
  assign mag_b  = b_neg ? -b_ext : b_ext;
  assign div0   = (b_ext == '0);
  // Most-negative / -1; the W form sees the 32-bit minimum sign-extended.
  assign ovf    = sgn_in && (b_ext == '1) &&
                  (bus.is_w_in ? (a_ext == 64'hFFFF_FFFF_8000_0000)
                               : (a_ext == 64'h8000_0000_0000_0000));
  assign quo_spec = div0 ? '1 : (bus.is_w_in ? a_w : bus.src1_in);
  assign rem_spec = div0 ? (bus.is_w_in ? a_w : bus.src1_in) : '0;
  assign spec_res = bus.error_in ? '0 : (rem_in ? rem_spec : quo_spec);

  // Iteration step and final fix-up on the step output.
  logic [XLEN-1:0] step_rem, step_quo, fix_q, fix_r, pick, fin_res;

  ysyx_220066_div_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign fix_q   = negq_q ? -step_quo : step_quo;
  assign fix_r   = negr_q ? -step_rem : step_rem;
  assign pick    = is_rem_q ? fix_r : fix_q;
  assign fin_res = is_w_q ? ext32(pick[31:0], 1'b1) : pick;

  // Next-state and datapath updates; every register holds by default.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    is_rem_d  = is_rem_q;
    is_w_d    = is_w_q;
    rd_part_d = rd_part_q;
    rd_d      = rd_q;
    result_d  = result_q;
    nxtpc_d   = nxtpc_q;
    error_d   = error_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.valid_in) begin
          error_d = bus.error_in;
          nxtpc_d = bus.nxtpc_in;
          if (bus.error_in || div0 || ovf) begin
            result_d = spec_res;
            rd_d     = bus.rd_in;
            state_d  = S_DONE;
          end else begin
            rd_part_d = bus.rd_in;
            is_rem_d  = rem_in;
            is_w_d    = bus.is_w_in;
            negq_d    = a_neg ^ b_neg;
            negr_d    = a_neg;
            dvs_d     = mag_b;
            rem_d     = '0;
            // W dividends sit in the top half so 32 shifts consume them.
            quo_d     = bus.is_w_in ? {mag_a[31:0], 32'b0} : mag_a;
            cnt_d     = bus.is_w_in ? 7'd32 : 7'd64;
            state_d   = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          result_d = fin_res;
          rd_d     = rd_part_q;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (!bus.block) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      is_rem_q  <= 1'b0;
      is_w_q    <= 1'b0;
      rd_part_q <= '0;
      rd_q      <= '0;
      result_q  <= '0;
      nxtpc_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      is_rem_q  <= is_rem_d;
      is_w_q    <= is_w_d;
      rd_part_q <= rd_part_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      nxtpc_q   <= nxtpc_d;
      error_q   <= error_d;
    end
  end

  assign bus.ready      = (state_q == S_IDLE);
  assign bus.valid_part = (state_q == S_BUSY);
  assign bus.valid      = (state_q == S_DONE);
  assign bus.rd_part    = rd_part_q;
  assign bus.rd         = rd_q;
  assign bus.result     = result_q;
  assign bus.error      = error_q;
  assign bus.nxtpc      = nxtpc_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_ysyx_220066_divider.sv
// Directed bench for ysyx_220066_divider: vector table plus hazard/stall and
// mid-operation reset sequences.
module tb_ysyx_220066_divider;
  logic clk = 1'b0;
  logic rst = 1'b0;

  ysyx_220066_divider_if bus();

  ysyx_220066_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]  ctr;
    logic        w;
    logic        err;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Driver: wait for ready, present the op for one accept edge.
  task automatic issue(input logic [1:0] ctr, input logic w, input logic err,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] r, input logic [63:0] pc);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) check("ready_timeout", 64'(bus.ready), 64'd1);
    bus.ALUctr_in = ctr;
    bus.is_w_in   = w;
    bus.error_in  = err;
    bus.src1_in   = a;
    bus.src2_in   = b;
    bus.rd_in     = r;
    bus.nxtpc_in  = pc;
    bus.valid_in  = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in  = 1'b0;
  endtask

  // Count edges after the accept edge until valid rises.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.valid) check("valid_timeout", 64'(bus.valid), 64'd1);
  endtask

  initial begin
    int lat;
    bus.block     = 1'b0;
    bus.valid_in  = 1'b0;
    bus.error_in  = 1'b0;
    bus.nxtpc_in  = '0;
    bus.src1_in   = '0;
    bus.src2_in   = '0;
    bus.ALUctr_in = 2'b00;
    bus.is_w_in   = 1'b0;
    bus.rd_in     = '0;

    //            ctr    w     err   a                       b                       exp                     lat
    vecs[0]  = '{2'b00, 1'b0, 1'b0, -64'sd7,                64'd2,                  64'hFFFF_FFFF_FFFF_FFFD, 64};
    vecs[1]  = '{2'b10, 1'b0, 1'b0, -64'sd7,                64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, 64};
    vecs[2]  = '{2'b01, 1'b1, 1'b0, 64'hFFFF_FFFF,          64'd1,                  64'hFFFF_FFFF_FFFF_FFFF, 32};
    vecs[3]  = '{2'b01, 1'b0, 1'b0, 64'd5,                  64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[4]  = '{2'b11, 1'b0, 1'b0, 64'd5,                  64'd0,                  64'd5,                   0};
    vecs[5]  = '{2'b00, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0};
    vecs[6]  = '{2'b10, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                  0};
    vecs[7]  = '{2'b10, 1'b1, 1'b0, 64'h8000_0000,          64'hFFFF_FFFF,          64'd0,                   0};
    vecs[8]  = '{2'b01, 1'b0, 1'b0, 64'd100,                64'd7,                  64'd14,                  64};
    vecs[9]  = '{2'b11, 1'b0, 1'b0, 64'd100,                64'd7,                  64'd2,                   64};
    vecs[10] = '{2'b00, 1'b0, 1'b0, 64'd7,                  -64'sd2,                64'hFFFF_FFFF_FFFF_FFFD, 64};
    vecs[11] = '{2'b10, 1'b0, 1'b0, 64'd7,                  -64'sd2,                64'd1,                   64};
    vecs[12] = '{2'b00, 1'b1, 1'b0, 64'hFFFF_FFF9,          64'd2,                  64'hFFFF_FFFF_FFFF_FFFD, 32};
    vecs[13] = '{2'b11, 1'b1, 1'b0, 64'h1_0000_000A,        64'd3,                  64'd1,                   32};
    vecs[14] = '{2'b00, 1'b1, 1'b0, 64'h1234_5678,          64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[15] = '{2'b10, 1'b1, 1'b0, 64'h8000_0001,          64'd0,                  64'hFFFF_FFFF_8000_0001, 0};
    vecs[16] = '{2'b01, 1'b1, 1'b0, 64'h8000_0000,          64'hFFFF_FFFF,          64'd0,                   32};
    vecs[17] = '{2'b01, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,                64'h0FFF_FFFF_FFFF_FFFF, 64};
    vecs[18] = '{2'b11, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,                64'hF,                   64};
    vecs[19] = '{2'b00, 1'b0, 1'b1, 64'd9,                  64'd3,                  64'd0,                   0};
    vecs[20] = '{2'b00, 1'b1, 1'b0, 64'h8000_0000,          64'hFFFF_FFFF,          64'hFFFF_FFFF_8000_0000, 0};
    vecs[21] = '{2'b10, 1'b1, 1'b0, 64'hFFFF_FFF9,          64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, 32};

    // Reset values while rst is held low.
    #3;
    check("rst_ready",      64'(bus.ready),      64'd1);
    check("rst_valid",      64'(bus.valid),      64'd0);
    check("rst_valid_part", 64'(bus.valid_part), 64'd0);
    check("rst_rd",         64'(bus.rd),         64'd0);
    check("rst_rd_part",    64'(bus.rd_part),    64'd0);
    check("rst_result",     bus.result,          64'd0);
    check("rst_error",      64'(bus.error),      64'd0);
    check("rst_nxtpc",      bus.nxtpc,           64'd0);
    #9;
    rst = 1'b1;

    // Vector table.
    for (int i = 0; i < 22; i++) begin
      issue(vecs[i].ctr, vecs[i].w, vecs[i].err, vecs[i].a, vecs[i].b,
            5'(i + 1), 64'h8000_0000 + 64'(i * 4));
      wait_valid(lat);
      check($sformatf("v%0d_latency", i), 64'(lat),       64'(vecs[i].lat));
      check($sformatf("v%0d_result", i),  bus.result,     vecs[i].exp);
      check($sformatf("v%0d_rd", i),      64'(bus.rd),    64'(i + 1));
      check($sformatf("v%0d_error", i),   64'(bus.error), 64'(vecs[i].err));
      check($sformatf("v%0d_nxtpc", i),   bus.nxtpc,      64'h8000_0000 + 64'(i * 4));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_release_ready", i), 64'(bus.ready), 64'd1);
      check($sformatf("v%0d_release_valid", i), 64'(bus.valid), 64'd0);
    end

    // Hazard visibility, ignored issue while busy, and write-back stall.
    bus.block = 1'b1;
    issue(2'b01, 1'b0, 1'b0, 64'd100, 64'd7, 5'd17, 64'h1000);
    check("busy_valid_part", 64'(bus.valid_part), 64'd1);
    check("busy_rd_part",    64'(bus.rd_part),    64'd17);
    check("busy_ready",      64'(bus.ready),      64'd0);
    @(negedge clk);
    bus.rd_in    = 5'd3;
    bus.src1_in  = 64'd50;
    bus.valid_in = 1'b1;
    repeat (5) @(negedge clk);
    bus.valid_in = 1'b0;
    check("busy_rd_part_held", 64'(bus.rd_part), 64'd17);
    wait_valid(lat);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_valid", k),  64'(bus.valid), 64'd1);
      check($sformatf("stall%0d_result", k), bus.result,     64'd14);
      check($sformatf("stall%0d_rd", k),     64'(bus.rd),    64'd17);
    end
    bus.block = 1'b0;
    @(posedge clk);
    #1;
    check("unstall_valid",   64'(bus.valid), 64'd0);
    check("unstall_ready",   64'(bus.ready), 64'd1);
    check("unstall_rd_held", 64'(bus.rd),    64'd17);

    // Asynchronous reset pulse in the middle of BUSY.
    issue(2'b00, 1'b0, 1'b0, -64'sd7, 64'd2, 5'd9, 64'h2000);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_ready",      64'(bus.ready),      64'd1);
    check("arst_valid",      64'(bus.valid),      64'd0);
    check("arst_valid_part", 64'(bus.valid_part), 64'd0);
    check("arst_rd",         64'(bus.rd),         64'd0);
    check("arst_rd_part",    64'(bus.rd_part),    64'd0);
    check("arst_result",     bus.result,          64'd0);
    check("arst_nxtpc",      bus.nxtpc,           64'd0);
    #2;
    rst = 1'b1;
    issue(2'b10, 1'b0, 1'b0, -64'sd7, 64'd2, 5'd4, 64'h3000);
    wait_valid(lat);
    check("post_rst_latency", 64'(lat),    64'd64);
    check("post_rst_result",  bus.result,  64'hFFFF_FFFF_FFFF_FFFF);
    check("post_rst_rd",      64'(bus.rd), 64'd4);
    check("post_rst_nxtpc",   bus.nxtpc,   64'h3000);
    @(posedge clk);
    #1;
    check("post_rst_ready", 64'(bus.ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
